// File: rtl/ctr_pkg.sv
// Shared constants for the bounded up/down counter family.
package ctr_pkg;

    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mode_ctr_if.sv
// Control/status bundle between a counter user (master) and mode_ctr (slave).
interface mode_ctr_if #(
    parameter int WIDTH = 3
) ();

    logic             ctr_rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             at_max;
    logic             at_min;
    logic             err;

    modport master (
        output ctr_rst, en, up, load, load_val,
        input  out, at_max, at_min, err
    );

    modport slave (
        input  ctr_rst, en, up, load, load_val,
        output out, at_max, at_min, err
    );

endinterface

// File: rtl/dff.sv
// Single-bit flop with synchronous active-high clear.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/mode_ctr_next.sv
// Combinational step of the counter: +/-1 with saturate or wrap at 0 and MAX.
module ctr_next
    import ctr_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MAX   = 5,
    parameter int MODE  = MODE_SAT
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic             up_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] nxt_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    always_comb begin
        nxt_o = cur_i;
        if (en_i) begin
            if (up_i) begin
                if (cur_i == MAX_V) nxt_o = (MODE == MODE_WRAP) ? '0 : MAX_V;
                else                nxt_o = cur_i + ONE_V;
            end else begin
                if (cur_i == '0)    nxt_o = (MODE == MODE_WRAP) ? MAX_V : '0;
                else                nxt_o = cur_i - ONE_V;
            end
        end
    end

endmodule

// File: rtl/mode_ctr.sv
// Bounded up/down counter with load clamp, sticky error and a one-cycle HOLD after reset.
module mode_ctr
    import ctr_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MAX   = 5,
    parameter int MODE  = MODE_SAT
) (
    input  logic       clk,
    input  logic       rst,
    mode_ctr_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] out_q, out_d, step_val;
    logic             err_q, err_d;
    state_e           state_q, state_d;
    logic             state_bit_q;

    ctr_next #(.WIDTH(WIDTH), .MAX(MAX), .MODE(MODE)) u_next (
        .cur_i (out_q),
        .up_i  (bus.up),
        .en_i  (bus.en),
        .nxt_o (step_val)
    );

    // Priority below rst (handled by the flops): clear, HOLD, load, step.
    always_comb begin
        state_d = ST_RUN;
        out_d   = out_q;
        err_d   = err_q;
        if (bus.ctr_rst) begin
            out_d = '0;
            err_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (bus.load) begin
                if (bus.load_val > MAX_V) begin
                    out_d = MAX_V;
                    err_d = 1'b1;
                end else begin
                    out_d = bus.load_val;
                end
            end else begin
                out_d = step_val;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_out
        dff u_out (.clk(clk), .rst(rst), .d_i(out_d[g]), .q_o(out_q[g]));
    end

    dff u_err   (.clk(clk), .rst(rst), .d_i(err_d),          .q_o(err_q));
    dff u_state (.clk(clk), .rst(rst), .d_i(logic'(state_d)), .q_o(state_bit_q));

    assign state_q    = state_e'(state_bit_q);
    assign bus.out    = out_q;
    assign bus.err    = err_q;
    assign bus.at_max = (out_q == MAX_V);
    assign bus.at_min = (out_q == '0);

endmodule

// File: tb/tb_mode_ctr.sv
// Directed checks of mode_ctr: saturate (3b/5), wrap (3b/5) and wide wrap (8b/200) instances.
module tb_mode_ctr;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mode_ctr_if #(.WIDTH(3)) if0 ();
    mode_ctr_if #(.WIDTH(3)) if1 ();
    mode_ctr_if #(.WIDTH(8)) if2 ();

    mode_ctr #(.WIDTH(3), .MAX(5),   .MODE(0)) u_sat  (.clk(clk), .rst(rst), .bus(if0));
    mode_ctr #(.WIDTH(3), .MAX(5),   .MODE(1)) u_wrap (.clk(clk), .rst(rst), .bus(if1));
    mode_ctr #(.WIDTH(8), .MAX(200), .MODE(1)) u_wide (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq_sat[7];
        int seq_wrap[6];
        seq_sat  = '{1, 2, 3, 4, 5, 5, 5};
        seq_wrap = '{5, 0, 1, 0, 5, 4};

        rst = 1'b1;
        {if0.ctr_rst, if0.en, if0.up, if0.load, if0.load_val} = '0;
        {if1.ctr_rst, if1.en, if1.up, if1.load, if1.load_val} = '0;
        {if2.ctr_rst, if2.en, if2.up, if2.load, if2.load_val} = '0;
        tick();
        tick();
        chk("rst_out",    int'(if0.out),    0);
        chk("rst_at_min", int'(if0.at_min), 1);
        chk("rst_at_max", int'(if0.at_max), 0);
        chk("rst_err",    int'(if0.err),    0);
        chk("rst_wide",   int'(if2.out),    0);

        // Reset and hold, then saturating count-up
        rst = 1'b0; if0.en = 1'b1; if0.up = 1'b1;
        tick();
        chk("hold_edge", int'(if0.out), 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("sat_up%0d", i), int'(if0.out), seq_sat[i]);
        end
        chk("sat_at_max", int'(if0.at_max), 1);
        chk("sat_err",    int'(if0.err),    0);

        // Saturate down from 1
        if0.load = 1'b1; if0.load_val = 3'd1;
        tick();
        chk("ld1", int'(if0.out), 1);
        if0.load = 1'b0; if0.up = 1'b0;
        tick();
        chk("dn0", int'(if0.out), 0);
        tick();
        chk("dn_sat",    int'(if0.out),    0);
        chk("dn_at_min", int'(if0.at_min), 1);
        chk("dn_err",    int'(if0.err),    0);
        if0.en = 1'b0;

        // Wrap mode: up from 4, then down from 1
        if1.load = 1'b1; if1.load_val = 3'd4; if1.en = 1'b1; if1.up = 1'b1;
        tick();
        chk("wrap_ld4", int'(if1.out), 4);
        if1.load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) if1.up = 1'b0;
            tick();
            chk($sformatf("wrap%0d", i), int'(if1.out), seq_wrap[i]);
        end
        if1.en = 1'b0;

        // Load: in range, boundary, over range, sticky err, clear
        if0.load = 1'b1; if0.load_val = 3'd3;
        tick();
        chk("ld3_out", int'(if0.out), 3);
        chk("ld3_err", int'(if0.err), 0);
        if0.load_val = 3'd5;
        tick();
        chk("ld5_out", int'(if0.out), 5);
        chk("ld5_err", int'(if0.err), 0);
        if0.load_val = 3'd7;
        tick();
        chk("ld7_out", int'(if0.out), 5);
        chk("ld7_err", int'(if0.err), 1);
        if0.load = 1'b0; if0.en = 1'b1; if0.up = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("sticky_err", int'(if0.err), 1);
        chk("sticky_out", int'(if0.out), 0);
        if0.en = 1'b0; if0.ctr_rst = 1'b1;
        tick();
        chk("clr_out", int'(if0.out), 0);
        chk("clr_err", int'(if0.err), 0);
        if0.ctr_rst = 1'b0;

        // Collisions: load beats en; ctr_rst beats load
        if0.load = 1'b1; if0.load_val = 3'd2; if0.en = 1'b1; if0.up = 1'b1;
        tick();
        chk("ld_en", int'(if0.out), 2);
        if0.en = 1'b0; if0.load_val = 3'd7;
        tick();
        chk("pre_clr_err", int'(if0.err), 1);
        if0.ctr_rst = 1'b1;
        tick();
        chk("clr_ld_out", int'(if0.out), 0);
        chk("clr_ld_err", int'(if0.err), 0);
        if0.ctr_rst = 1'b0; if0.load = 1'b0;

        // rst mid-count at 4, then HOLD edge ignores en and load
        if0.en = 1'b1; if0.up = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst", int'(if0.out), 4);
        rst = 1'b1;
        tick();
        chk("mid_rst", int'(if0.out), 0);
        rst = 1'b0; if1.load = 1'b1; if1.load_val = 3'd3;
        tick();
        chk("post_hold",    int'(if0.out), 0);
        chk("hold_no_load", int'(if1.out), 0);
        tick();
        chk("resume",    int'(if0.out), 1);
        chk("resume_ld", int'(if1.out), 3);
        if0.en = 1'b0; if1.load = 1'b0;

        // Wide wrap variant
        if2.load = 1'b1; if2.load_val = 8'd199; if2.en = 1'b1; if2.up = 1'b1;
        tick();
        chk("wide_ld199", int'(if2.out), 199);
        if2.load = 1'b0;
        tick();
        chk("wide_200",    int'(if2.out),    200);
        chk("wide_at_max", int'(if2.at_max), 1);
        tick();
        chk("wide_wrap0", int'(if2.out), 0);
        if2.load = 1'b1; if2.load_val = 8'd255;
        tick();
        chk("wide_clamp", int'(if2.out), 200);
        chk("wide_err",   int'(if2.err), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
